// File: rtl/seq_multiplier64_pkg.sv
// Shared constants and state encoding for the 64x64 shift-and-add multiplier.
package seq_mul_pkg;

    localparam int ITER  = 64;
    localparam int CNT_W = 6;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // True when the request pulse may be taken in the given state.
    function automatic logic can_accept(input state_t st);
        return (st == IDLE) || (st == DONE);
    endfunction

endpackage

// File: rtl/seq_multiplier64_if.sv
// Start/operand/result bundle between the ALU (master) and the multiplier (slave).
interface seq_multiplier64_if;

    logic         start;
    logic [63:0]  A;
    logic [63:0]  B;
    logic [127:0] P;
    logic         busy;
    logic         done;

    modport master (
        output start,
        output A,
        output B,
        input  P,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  A,
        input  B,
        output P,
        output busy,
        output done
    );

endinterface

// File: rtl/seq_multiplier64_cla.sv
// 64-bit carry-lookahead adder: 4-bit lookahead groups chained on group carries.
module CLA_adder64bit (
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic        Cin,
    output logic [63:0] S,
    output logic        Cout
);

    logic [63:0] g;
    logic [63:0] p;
    logic [63:0] c;
    logic [15:0] grp_g;
    logic [15:0] grp_p;
    logic [16:0] grp_c;

    assign g        = A & B;
    assign p        = A ^ B;
    assign grp_c[0] = Cin;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_grp
            localparam int B0 = 4 * gi;

            assign grp_g[gi] = g[B0+3]
                             | (p[B0+3] & g[B0+2])
                             | (p[B0+3] & p[B0+2] & g[B0+1])
                             | (p[B0+3] & p[B0+2] & p[B0+1] & g[B0]);
            assign grp_p[gi] = &p[B0+3:B0];

            // In-group carries are flattened so each bit sees only the group carry-in.
            assign c[B0]   = grp_c[gi];
            assign c[B0+1] = g[B0] | (p[B0] & grp_c[gi]);
            assign c[B0+2] = g[B0+1] | (p[B0+1] & g[B0])
                           | (p[B0+1] & p[B0] & grp_c[gi]);
            assign c[B0+3] = g[B0+2] | (p[B0+2] & g[B0+1])
                           | (p[B0+2] & p[B0+1] & g[B0])
                           | (p[B0+2] & p[B0+1] & p[B0] & grp_c[gi]);

            assign grp_c[gi+1] = grp_g[gi] | (grp_p[gi] & grp_c[gi]);
        end
    endgenerate

    assign S    = p ^ c;
    assign Cout = grp_c[16];

endmodule

// File: rtl/seq_multiplier64.sv
// Unsigned 64x64->128 shift-and-add multiplier; one adder pass per cycle over 64 cycles.
module seq_multiplier64
    import seq_mul_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    seq_multiplier64_if.slave  bus
);

    state_t           state_reg, state_next;
    logic [63:0]      mcand_reg, mcand_next;
    logic [63:0]      hi_reg,    hi_next;
    logic [63:0]      lo_reg,    lo_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;

    logic [63:0] add_b;
    logic [63:0] add_s;
    logic        add_cout;
    logic        accept;

    assign add_b = lo_reg[0] ? mcand_reg : 64'd0;

    CLA_adder64bit u_adder (
        .A    (hi_reg),
        .B    (add_b),
        .Cin  (1'b0),
        .S    (add_s),
        .Cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            mcand_reg <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            mcand_reg <= mcand_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign accept = bus.start && can_accept(state_reg);

    always_comb begin
        state_next = state_reg;
        mcand_next = mcand_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        cnt_next   = cnt_reg;

        unique case (state_reg)
            IDLE, DONE: begin
                if (accept) begin
                    mcand_next = bus.A;
                    lo_next    = bus.B;
                    hi_next    = '0;
                    cnt_next   = '0;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                // The adder carry-out becomes bit 127 of the shifted partial product.
                if (lo_reg[0]) begin
                    hi_next = {add_cout, add_s[63:1]};
                    lo_next = {add_s[0], lo_reg[63:1]};
                end else begin
                    hi_next = {1'b0, hi_reg[63:1]};
                    lo_next = {hi_reg[0], lo_reg[63:1]};
                end
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.P    = {hi_reg, lo_reg};
    assign bus.busy = (state_reg == RUN);
    assign bus.done = (state_reg == DONE);

endmodule

// File: doc/seq_multiplier64.md
# seq_multiplier64

Multi-cycle 64×64 → 128-bit unsigned shift-and-add multiplier for the ALU. Each cycle it drives the existing 64-bit carry-lookahead adder (CLA_adder64bit) with the running high partial product and the multiplicand, then consumes the adder's sum and carry-out. It sits directly upstream of the adder and feeds it. The ALU issues a one-cycle start and waits for a one-cycle done.

## Interface
Parameters:
- none; width is fixed at 64 by the adder. ITER = 64 lives in the package.

Ports (reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE or DONE
- A  in  64  multiplicand; captured on the accepting edge
- B  in  64  multiplier; captured on the accepting edge
- P  out  128  product; valid while done = 1; held until the next accepted start
- busy  out  1  high while iterating
- done  out  1  one-cycle pulse when P is valid

## Operation
Registers:
- mcand[63:0]
- hi[63:0]
- lo[63:0] (holds the multiplier, shifted right)
- cnt[5:0]
- state

States:
- IDLE: start=1 → mcand←A, lo←B, hi←0, cnt←0, go to RUN.
- RUN: one iteration per edge.
  - Adder inputs: A=hi, B=(lo[0] ? mcand : 0), Cin=0.
  - {hi,lo} ← {Cout, S, lo[63:1]} when lo[0]=1.
  - {hi,lo} ← {1'b0, hi, lo[63:1]} when lo[0]=0; the adder output is still computed but ignored.
  - cnt←cnt+1.
  - cnt==63 → go to DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 → accept, as in IDLE, and go to RUN.
  - start=0 → go to IDLE.

Outputs:
- P = {hi,lo}, combinational from the registers. It is stable in DONE and in the following IDLE.
- busy = (state==RUN).
- start while busy is ignored; it is neither queued nor flagged.
- A and B may change freely after the accepting edge.
- Arithmetic is unsigned; overflow is impossible, since the 128-bit result is exact. Cout of the adder is bit 64 of each partial sum and must be kept.

Reset (asynchronous, any time, including mid-RUN):
- state←IDLE.
- hi, lo, mcand, cnt ← 0.
- P=0, busy=0, done=0.
- No done pulse for an aborted operation.
- The first edge after rst deasserts may accept start.

## Timing
- Edge t0 accepts start.
- RUN edges are t0+1 … t0+64, so busy=1 for exactly 64 cycles.
- done=1 during the cycle after edge t0+64; latency from start to done is 65 edges.
- Back-to-back: start held high during the DONE cycle gives an accept at t0+65, and the next done follows at t0+130. No idle bubble is required.
- A start in IDLE exactly one cycle after DONE also works (accept at t0+66).
- The adder path is fully combinational within a cycle. The reg→adder→reg path is the critical path, and no extra pipelining is allowed.

## Structure
- Package seq_mul_pkg:
  - ITER=64
  - CNT_W=6
  - state enum {IDLE, RUN, DONE} encoded 2'b00/01/10
- Sub-module: one instance of CLA_adder64bit (Cin tied 0).
- The iteration datapath, the FSM and the counter live in this module; no other sub-modules.

## Test plan
- A=3, B=5, start one cycle → busy for 64 cycles, done at edge t0+65, P=15, then IDLE with P held at 15.
- A=B=64'hFFFF_FFFF_FFFF_FFFF → P=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001. Checks Cout retention on every iteration.
- A=0, B=any; then A=any, B=0 → P=0 in both cases. A=1, B=64'h8000_0000_0000_0000 → P=128'h0000_0000_0000_0000_8000_0000_0000_0000.
- start pulsed at cycles t0+10 and t0+40 while busy, with A and B changed at the same time → ignored; the result still uses the t0 operands, and exactly one done pulse occurs.
- rst asserted asynchronously mid-RUN (cnt≈30) → busy, done and P go to 0 immediately, with no done pulse. A fresh start after deassert gives a correct product.
- Back-to-back: start high in the DONE cycle with A=7, B=9 → second done 65 edges later with P=63. A random 1000-operation run is checked against a 128-bit reference model.
